// File: rtl/game_flow_ctrl.sv
// Game sequencer for the Jack-Frost platformer: begin / playing / win / lose.
// Owns health, score, collected-snowflake and iced-block masks, and the level restart pulse.
module game_flow_ctrl #(
   parameter int GROUND_NUM      = 50,
   parameter int SNOW_NUM        = 15,
   parameter int MON_NUM         = 2,
   parameter int HEALTH_INIT     = 3,
   parameter int INVULN_FRAMES   = 60,
   parameter int END_HOLD_FRAMES = 120
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  frame_tick,
   input  logic                  start_key,
   input  logic [GROUND_NUM-1:0] bk_touched,
   input  logic [SNOW_NUM-1:0]   snowf_get,
   input  logic [MON_NUM-1:0]    slim_damage,
   output logic [1:0]            game,
   output logic [3:0]            health,
   output logic [3:0]            score,
   output logic                  level_rst,
   output logic                  move_en,
   output logic                  invuln,
   output logic [SNOW_NUM-1:0]   snow_mask,
   output logic [GROUND_NUM-1:0] ice_mask
);

   localparam int INV_W  = $clog2(INVULN_FRAMES + 1);
   localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);

   localparam logic [INV_W-1:0]  INV_LOAD    = INV_W'(INVULN_FRAMES);
   localparam logic [INV_W-1:0]  INV_ONE     = INV_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(END_HOLD_FRAMES);
   localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
   localparam logic [3:0]        HEALTH_LOAD = 4'(HEALTH_INIT);

   // State codes double as the game output encoding.
   typedef enum logic [1:0] {
      ST_BEGIN   = 2'b00,
      ST_PLAYING = 2'b01,
      ST_LOSE    = 2'b10,
      ST_WIN     = 2'b11
   } state_t;

   state_t                state;
   state_t                state_n;
   logic [3:0]            health_n;
   logic [3:0]            score_n;
   logic [SNOW_NUM-1:0]   snow_n;
   logic [GROUND_NUM-1:0] ice_n;
   logic [INV_W-1:0]      inv_cnt;
   logic [INV_W-1:0]      inv_n;
   logic [HOLD_W-1:0]     hold_cnt;
   logic [HOLD_W-1:0]     hold_n;
   logic                  level_rst_n;
   logic                  move_en_n;
   logic                  invuln_n;
   logic                  start_q;
   logic                  start_rise;
   logic                  hit;

   function automatic logic [3:0] flake_count(input logic [SNOW_NUM-1:0] v);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < SNOW_NUM; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return (cnt > 5'd15) ? 4'd15 : cnt[3:0];
   endfunction

   always_comb begin
      start_rise  = start_key & ~start_q;
      hit         = (|slim_damage) && (inv_cnt == '0) && (health != 4'd0);
      state_n     = state;
      health_n    = health;
      score_n     = flake_count(snow_mask);
      snow_n      = snow_mask;
      ice_n       = ice_mask;
      hold_n      = hold_cnt;
      level_rst_n = 1'b0;
      inv_n       = (frame_tick && (inv_cnt != '0)) ? (inv_cnt - INV_ONE) : inv_cnt;

      case (state)
         ST_BEGIN: begin
            if (start_rise) begin
               state_n     = ST_PLAYING;
               level_rst_n = 1'b1;
               snow_n      = '0;
               ice_n       = '0;
               health_n    = HEALTH_LOAD;
               score_n     = 4'd0;
               inv_n       = '0;
            end
         end
         ST_PLAYING: begin
            snow_n = snow_mask | snowf_get;
            ice_n  = ice_mask | bk_touched;
            // A fresh hit reloads the window even if a frame tick arrives in the same cycle.
            if (hit) begin
               health_n = health - 4'd1;
               inv_n    = INV_LOAD;
            end
            if (health == 4'd0) begin
               state_n = ST_LOSE;
               hold_n  = '0;
            end else if (&ice_mask) begin
               state_n = ST_WIN;
               hold_n  = '0;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (frame_tick && (hold_cnt < HOLD_MAX)) begin
               hold_n = hold_cnt + HOLD_ONE;
            end
            if (start_rise && (hold_cnt == HOLD_MAX)) begin
               state_n = ST_BEGIN;
            end
         end
         default: begin
            state_n = ST_BEGIN;
         end
      endcase

      move_en_n = (state_n == ST_PLAYING);
      invuln_n  = (inv_n != '0);
   end

   // start_q resets high so a key held through reset never counts as a press.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= ST_BEGIN;
         health    <= HEALTH_LOAD;
         score     <= 4'd0;
         snow_mask <= '0;
         ice_mask  <= '0;
         inv_cnt   <= '0;
         hold_cnt  <= '0;
         level_rst <= 1'b0;
         move_en   <= 1'b0;
         invuln    <= 1'b0;
         start_q   <= 1'b1;
      end else begin
         state     <= state_n;
         health    <= health_n;
         score     <= score_n;
         snow_mask <= snow_n;
         ice_mask  <= ice_n;
         inv_cnt   <= inv_n;
         hold_cnt  <= hold_n;
         level_rst <= level_rst_n;
         move_en   <= move_en_n;
         invuln    <= invuln_n;
         start_q   <= start_key;
      end
   end

   assign game = state;

endmodule
